// File: rtl/pcm_to_dsm_modulator_pkg.sv
// Shared constants and arithmetic helpers for the PCM to 1-bit delta-sigma path.
// Every other file pulls these in with a wildcard import.
package pcm_to_dsm_modulator_pkg;

    localparam int CIC_R      = 64;
    localparam int CIC_N      = 3;
    localparam int CIC_W      = 40;
    localparam int GAIN_SHIFT = 12;
    localparam int PCM_W      = 24;
    localparam int STATE_W    = 32;
    localparam int FS         = 1 << 23;
    localparam int CLAMP_LIM  = 1 << 22;
    localparam int SAT_LIM    = 1 << 30;

    // Inputs beyond half scale would push the 2nd-order loop out of its stable range.
    function automatic logic signed [PCM_W-1:0] clamp_pcm(input logic signed [PCM_W-1:0] s);
        logic signed [PCM_W-1:0] lim;
        lim = PCM_W'(CLAMP_LIM);
        if (s > lim) return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

    function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [STATE_W+1:0] v);
        logic signed [STATE_W+1:0] lim;
        lim = (STATE_W+2)'(SAT_LIM);
        if (v > lim) return STATE_W'(SAT_LIM);
        if (v < -lim) return -STATE_W'(SAT_LIM);
        return v[STATE_W-1:0];
    endfunction

endpackage

// File: rtl/cic_interpolator_r64_n3.sv
// CIC interpolator: combs at frame rate, zero-stuffing, integrators at tick rate.
// Output is the last integrator scaled back by the R^(N-1) DC gain.
module cic_interpolator_r64_n3 #(
    parameter int CIC_N      = 3,
    parameter int CIC_W      = 40,
    parameter int GAIN_SHIFT = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        frame,
    input  logic [23:0] din,
    output logic [23:0] dout
);
    import pcm_to_dsm_modulator_pkg::*;

    logic signed [CIC_W-1:0] comb_dly [CIC_N];
    logic signed [CIC_W-1:0] comb_y   [CIC_N+1];
    logic signed [CIC_W-1:0] integ    [CIC_N];
    logic signed [CIC_W-1:0] integ_in [CIC_N+1];

    // Integrator chain is not pipelined so a frame sample reaches the output on its own tick.
    always_comb begin
        comb_y[0] = {{(CIC_W-PCM_W){din[PCM_W-1]}}, din};
        for (int k = 0; k < CIC_N; k++) begin
            comb_y[k+1] = comb_y[k] - comb_dly[k];
        end
        integ_in[0] = frame ? comb_y[CIC_N] : '0;
        for (int k = 0; k < CIC_N; k++) begin
            integ_in[k+1] = integ[k] + integ_in[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CIC_N; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else if (tick) begin
            for (int k = 0; k < CIC_N; k++) begin
                integ[k] <= integ_in[k+1];
                if (frame) comb_dly[k] <= comb_y[k];
            end
        end
    end

    assign dout = integ[CIC_N-1][GAIN_SHIFT +: PCM_W];

endmodule

// File: rtl/pcm_to_dsm_modulator.sv
// PCM sample stream to 1-bit delta-sigma: 2-deep input FIFO, CIC upsampler,
// 2nd-order feedback loop. Handshake: a sample moves when pcm_valid && pcm_ready.
module pcm_to_dsm_modulator #(
    parameter int CIC_R = pcm_to_dsm_modulator_pkg::CIC_R,
    parameter int CIC_N = pcm_to_dsm_modulator_pkg::CIC_N
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    input  logic        dsm_en,
    output logic        dsm_out,
    output logic        dsm_valid,
    output logic        underrun
);
    import pcm_to_dsm_modulator_pkg::*;

    localparam int PHASE_W = $clog2(CIC_R);

    logic [PHASE_W-1:0]       phase;
    logic                     frame;

    logic signed [PCM_W-1:0]  fifo_mem [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic                     push;
    logic                     pop;
    logic                     empty;
    logic signed [PCM_W-1:0]  pcm_s;
    logic signed [PCM_W-1:0]  last_sample;
    logic signed [PCM_W-1:0]  cur_sample;

    logic [PCM_W-1:0]         x;
    logic signed [STATE_W-1:0] s1;
    logic signed [STATE_W-1:0] s2;
    logic                     v;
    logic signed [STATE_W+1:0] x_w;
    logic signed [STATE_W+1:0] fb_w;
    logic signed [STATE_W+1:0] s1_w;
    logic signed [STATE_W+1:0] s2_w;
    logic signed [STATE_W+1:0] e1;
    logic signed [STATE_W+1:0] e2;
    logic signed [STATE_W+1:0] s1_sum;
    logic signed [STATE_W+1:0] s2_sum;

    assign frame     = dsm_en && (phase == '0);
    assign empty     = (count == 2'd0);
    assign pcm_ready = (count != 2'd2);
    assign push      = pcm_valid && pcm_ready;
    assign pop       = frame && !empty;
    assign pcm_s     = pcm_in;

    // An empty FIFO at a frame boundary replays the previous sample.
    assign cur_sample = empty ? last_sample : fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (dsm_en) begin
            phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            last_sample <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= clamp_pcm(pcm_s);
                wr_ptr           <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (frame) last_sample <= cur_sample;
        end
    end

    cic_interpolator_r64_n3 #(
        .CIC_N      (CIC_N),
        .CIC_W      (CIC_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_cic (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (dsm_en),
        .frame (frame),
        .din   (cur_sample),
        .dout  (x)
    );

    // Two guard bits keep the unsaturated sums exact before clamping.
    assign v = !s2[STATE_W-1];

    always_comb begin
        x_w    = {{(STATE_W+2-PCM_W){x[PCM_W-1]}}, x};
        fb_w   = v ? (STATE_W+2)'(FS) : -(STATE_W+2)'(FS);
        s1_w   = {{2{s1[STATE_W-1]}}, s1};
        s2_w   = {{2{s2[STATE_W-1]}}, s2};
        e1     = x_w - fb_w;
        e2     = s1_w - fb_w;
        s1_sum = s1_w + (e1 >>> 1);
        s2_sum = s2_w + (e2 >>> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            dsm_out   <= 1'b0;
            dsm_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            dsm_valid <= dsm_en;
            underrun  <= frame && empty;
            if (dsm_en) begin
                s1      <= sat_state(s1_sum);
                s2      <= sat_state(s2_sum);
                dsm_out <= v;
            end
        end
    end

endmodule

// File: tb/tb_pcm_to_dsm_modulator.sv
// Directed bench for pcm_to_dsm_modulator: reset values, FIFO flow control,
// underrun pulses, mid-stream reset and ones density for several DC inputs.
module tb_pcm_to_dsm_modulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pcm_in;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        dsm_en;
    logic        dsm_out;
    logic        dsm_valid;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    int ones_cnt, valid_cnt, valid_long, underrun_cnt, underrun_long;
    int sat_hits = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pcm_to_dsm_modulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .dsm_en    (dsm_en),
        .dsm_out   (dsm_out),
        .dsm_valid (dsm_valid),
        .underrun  (underrun)
    );

    always @(negedge clk) begin
        if (rst_n && (dut.s1 >= 32'sd1073741824 || dut.s1 <= -32'sd1073741824 ||
                      dut.s2 >= 32'sd1073741824 || dut.s2 <= -32'sd1073741824))
            sat_hits++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp, input int tol);
        int diff;
        n_vec++;
        diff = got - exp;
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic clear_counts();
        ones_cnt      = 0;
        valid_cnt     = 0;
        valid_long    = 0;
        underrun_cnt  = 0;
        underrun_long = 0;
    endtask

    task automatic do_tick();
        dsm_en = 1'b1;
        @(posedge clk); #1;
        dsm_en = 1'b0;
        if (dsm_out)   ones_cnt++;
        if (dsm_valid) valid_cnt++;
        if (underrun)  underrun_cnt++;
        @(posedge clk); #1;
        if (dsm_valid) valid_long++;
        if (underrun)  underrun_long++;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        dsm_en    = 1'b0;
        pcm_valid = 1'b0;
        pcm_in    = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_density(input string tag, input logic [23:0] val, input int exp_ones);
        int sat_base;
        apply_reset();
        pcm_in    = val;
        pcm_valid = 1'b1;
        @(posedge clk); #1;
        repeat (256) do_tick();
        clear_counts();
        sat_base = sat_hits;
        exp_q.push_back(32'(exp_ones));
        repeat (4096) do_tick();
        check({tag, "_ones"}, ones_cnt, int'(exp_q.pop_front()), 20);
        check({tag, "_valid"}, valid_cnt, 4096, 0);
        check({tag, "_valid_width"}, valid_long, 0, 0);
        check({tag, "_no_underrun"}, underrun_cnt, 0, 0);
        check({tag, "_no_sat"}, sat_hits - sat_base, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pcm_valid = 1'b0;
        pcm_in    = '0;
        dsm_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", pcm_ready, 1, 0);
        check("rst_dsm_out", dsm_out, 0, 0);
        check("rst_dsm_valid", dsm_valid, 0, 0);
        check("rst_underrun", underrun, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty FIFO at the first boundary: one underrun pulse, none at phase 1.
        clear_counts();
        do_tick();
        check("empty_underrun", underrun_cnt, 1, 0);
        check("empty_underrun_width", underrun_long, 0, 0);
        check("empty_valid", valid_cnt, 1, 0);
        do_tick();
        check("phase1_no_underrun", underrun_cnt, 1, 0);

        // FIFO flow control with dsm_en held low.
        apply_reset();
        check("fifo_ready_empty", pcm_ready, 1, 0);
        pcm_valid = 1'b1;
        pcm_in    = 24'h000100;
        @(posedge clk); #1;
        check("fifo_ready_one", pcm_ready, 1, 0);
        pcm_in = 24'h000200;
        @(posedge clk); #1;
        check("fifo_full", pcm_ready, 0, 0);
        pcm_in = 24'h000300;
        @(posedge clk); #1;
        check("fifo_hold", pcm_ready, 0, 0);
        dsm_en = 1'b1;
        @(posedge clk); #1;
        dsm_en = 1'b0;
        check("fifo_pop_ready", pcm_ready, 1, 0);
        check("fifo_pop_underrun", underrun, 0, 0);
        check("fifo_pop_valid", dsm_valid, 1, 0);
        @(posedge clk); #1;
        check("fifo_refill", pcm_ready, 0, 0);
        pcm_valid = 1'b0;

        // Reset mid-frame while the FIFO is full and dsm_valid is high.
        apply_reset();
        pcm_in    = 24'h200000;
        pcm_valid = 1'b1;
        @(posedge clk); #1;
        repeat (100) do_tick();
        dsm_en = 1'b1;
        @(posedge clk); #1;
        dsm_en = 1'b0;
        check("pre_rst_valid", dsm_valid, 1, 0);
        check("pre_rst_full", pcm_ready, 0, 0);
        rst_n     = 1'b0;
        pcm_valid = 1'b0;
        #1;
        check("mid_rst_ready", pcm_ready, 1, 0);
        check("mid_rst_dsm_out", dsm_out, 0, 0);
        check("mid_rst_valid", dsm_valid, 0, 0);
        check("mid_rst_underrun", underrun, 0, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        pcm_valid = 1'b1;
        pcm_in    = 24'h100000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_rst_fill", pcm_ready, 0, 0);
        pcm_valid = 1'b0;
        clear_counts();
        do_tick();
        check("post_rst_first_pop", pcm_ready, 1, 0);
        repeat (127) do_tick();
        check("post_rst_two_pops", underrun_cnt, 0, 0);
        do_tick();
        check("post_rst_third_frame_underrun", underrun_cnt, 1, 0);

        // DC densities: p = (1 + x/FS) / 2 over 4096 ticks.
        run_density("dc_zero", 24'h000000, 2048);
        run_density("dc_neg_quarter", 24'hE00000, 1536);
        run_density("dc_clamp_max", 24'h7FFFFF, 3072);
        run_density("dc_clamp_min", 24'h800000, 1024);
        run_density("dc_pos_quarter", 24'h200000, 2560);

        // Feeding stops: two queued frames drain, then every boundary underruns.
        pcm_valid = 1'b0;
        clear_counts();
        repeat (128) do_tick();
        check("drain_no_underrun", underrun_cnt, 0, 0);
        clear_counts();
        repeat (4096) do_tick();
        check("starve_underruns", underrun_cnt, 64, 0);
        check("starve_underrun_width", underrun_long, 0, 0);
        check("starve_ones", ones_cnt, 2560, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcm_to_dsm_modulator.md
PCM_TO_DSM_MODULATOR -- requirements
Module: pcm_to_dsm_modulator

Interface
REQ-001 SHALL have parameter CIC_R, default 64, interpolation ratio (1.28 kHz -> 81.92 kHz).
REQ-002 SHALL have parameter CIC_N, default 3, CIC interpolator order.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pcm_in, input, 24 bits: signed two's-complement PCM sample.
REQ-006 SHALL have port pcm_valid, input, 1 bit: pcm_in is valid.
REQ-007 SHALL have port pcm_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 SHALL have port dsm_en, input, 1 bit: one-cycle tick at 81.92 kHz output bit rate.
REQ-009 SHALL have port dsm_out, output, 1 bit: modulator bit (1 = +FS, 0 = -FS).
REQ-010 SHALL have port dsm_valid, output, 1 bit: one-cycle pulse, dsm_out newly updated.
REQ-011 SHALL have port underrun, output, 1 bit: one-cycle pulse, frame needed a sample and FIFO was empty.

Function
REQ-012 SHALL buffer input in a 2-entry FIFO; pcm_ready = !full (combinational from count); transfer on pcm_valid && pcm_ready.
REQ-013 SHALL, in one cycle with push and pop both active, keep occupancy unchanged and preserve order.
REQ-014 SHALL clamp each accepted sample to [-2^22, +2^22] before storage (modulator stability limit 0.5 FS).
REQ-015 SHALL count dsm_en ticks with a 6-bit phase counter; a frame boundary is a dsm_en cycle with phase == 0; the counter wraps 63 -> 0.
REQ-016 SHALL pop one FIFO entry into the CIC comb section at each frame boundary; if the FIFO is empty, SHALL reuse the last popped sample (0 after reset) and pulse underrun.
REQ-017 SHALL run the CIC combs once per frame boundary, zero-stuff, and run the integrators on every dsm_en; all CIC stages are 40-bit signed, wrapping two's complement.
REQ-018 SHALL form modulator input x = CIC output arithmetically shifted right by 12 (gain R^(N-1) = 2^12), giving 24-bit signed x.
REQ-019 SHALL implement a 2nd-order loop with 32-bit signed states s1, s2; v = (s2 >= 0); fb = v ? +2^23 : -2^23.
REQ-020 SHALL, on each dsm_en: s1 <= sat(s1 + ((x - fb) >>> 1)); s2 <= sat(s2 + ((s1 - fb) >>> 1)); dsm_out <= v; sat() clamps to +/-2^30.
REQ-021 SHALL assert dsm_valid in the cycle after every dsm_en cycle, for exactly one cycle.
REQ-022 SHALL ignore dsm_en asserted on consecutive cycles only in that each asserted cycle is a full tick (no debounce); latency from pop to first effect on dsm_out SHALL be 2 dsm_en ticks.
REQ-023 SHALL hold all state when dsm_en = 0, except FIFO push.

Reset
REQ-024 SHALL, while rst_n = 0: FIFO empty, pcm_ready = 1, phase = 0, all CIC and loop states = 0, last sample = 0, dsm_out = 0, dsm_valid = 0, underrun = 0.
REQ-025 SHALL, on reset mid-stream, discard FIFO contents and restart at frame boundary phase 0.

Structure
REQ-026 SHALL place CIC_R, CIC_N, CIC width (40), gain shift (12), FS (2^23), clamp limit (2^22) and saturation limit (2^30) in a shared dsm package.
REQ-027 SHALL instantiate exactly one sub-module, cic_interpolator_r64_n3 (combs, zero-stuff, integrators); FIFO and modulator are written inline.

Verification
REQ-028 SHALL cover: reset -> pcm_ready=1, dsm_out=0, dsm_valid=0, underrun=0.
REQ-029 SHALL cover: constant pcm_in=0, 4096 ticks after 256-tick settle -> ones density 0.500 +/- 0.005.
REQ-030 SHALL cover: constant pcm_in=+2^21 -> density 0.625 +/- 0.005; pcm_in=24'h7FFFFF -> clamped, density 0.750 +/- 0.005, s1/s2 never saturate.
REQ-031 SHALL cover: 3 pushes with dsm_en=0 -> pcm_ready low after 2nd, 3rd held; next frame boundary pop -> pcm_ready high.
REQ-032 SHALL cover: feeding stops -> underrun one-cycle pulse at each empty frame boundary, density unchanged (last sample held).
REQ-033 SHALL cover: rst_n pulse mid-frame -> all REQ-024 values next cycle, first pop at 1st dsm_en after release.
